uart_tx_arbiter: RTL

Round-robin arbiter that shares the single host-side TX byte interface (tx_data/tx_valid/tx_ready) of Uart_core among NUM_REQ independent byte-stream requesters. A grant is locked for a whole frame, delimited by a per-requester last flag, so frames from different requesters never interleave on the serial line. A grant is also released after MAX_BURST bytes, and an optional idle gap is inserted between frames. It sits between on-chip message sources (debug, status, mailbox) and Uart_core.

---
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte port among NUM_REQ requesters.
// A grant is held for a whole frame, or until MAX_BURST bytes, then an optional idle gap.

module uart_tx_arb_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready
);
  // Unselected lanes contribute zero, so X on idle requesters never reaches tx_data.
  assign data_out = sel ? data : '0;
  assign ready    = sel & tx_ready;
endmodule

module uart_tx_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 64,
  parameter  int GAP_CYCLES = 0,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);
  localparam int BCW = ($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam int GCW = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [BCW-1:0] byte_cnt;
  logic [GCW-1:0] gap_cnt;
  logic [IDW-1:0] pick;
  logic           g_valid, g_last, xfer, burst_hit, rel;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    uart_tx_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel      (state == SEND && grant_id == IDW'(i)),
      .data     (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .tx_ready (tx_ready),
      .data_out (lane_data[i]),
      .ready    (req_ready[i])
    );
  end

  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) tx_data |= lane_data[i];
  end

  // Scan from last_grant+1 upward with wrap; first requester found wins.
  always_comb begin
    logic           found;
    logic [IDW-1:0] cand;
    found = 1'b0;
    pick  = last_grant;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign g_valid   = req_valid[grant_id];
  assign g_last    = req_last[grant_id];
  assign tx_valid  = (state == SEND) && g_valid;
  assign xfer      = tx_valid && tx_ready;
  assign burst_hit = (MAX_BURST != 0) && (int'(byte_cnt) + 1 == MAX_BURST);
  assign rel       = xfer && (g_last || burst_hit);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      byte_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          grant_id <= pick;
          state    <= SEND;
        end
        SEND: if (rel) begin
          last_grant <= grant_id;
          byte_cnt   <= '0;
          gap_cnt    <= '0;
          state      <= (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if (xfer) begin
          byte_cnt <= byte_cnt + 1'b1;
        end
        GAP: if (int'(gap_cnt) + 1 >= GAP_CYCLES) begin
          gap_cnt <= '0;
          state   <= IDLE;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
